// File: rtl/instr_loader.sv
// Boot-time instruction loader: receives a little-endian length header and program
// words over a valid/ready byte stream, fills a word memory, then serves fetches.
module instr_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          loaded,
  output logic          load_error,
  output logic [AW:0]   words_loaded,
  input  logic          enabled,
  input  logic [31:0]   pc,
  output logic [31:0]   instr_raw,
  output logic          completed,
  output logic [31:0]   pc_n
);

  // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are both 1;
  // rx_ready is a registered function of the state, so it never depends on rx_valid.

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   asm_q, asm_d;
  logic [31:0]   len_q, len_d;
  logic [AW:0]   words_q, words_d;
  logic          rx_ready_q, rx_ready_d;
  logic          loaded_q, loaded_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [31:0]   pc_n_q, pc_n_d;

  logic          accept;
  logic          wr_en;
  logic [31:0]   shifted;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          pc_in_range;

  logic [31:0]   mem [DEPTH];

  assign accept  = rx_valid & rx_ready_q;
  assign shifted = {rx_data, asm_q[31:8]};
  assign wr_idx  = words_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    len_d   = len_q;
    words_d = words_q;
    wr_en   = 1'b0;
    if (accept) begin
      asm_d = shifted;
      cnt_d = cnt_q + 2'd1;
      case (state_q)
        S_LEN: begin
          if (cnt_q == 2'd3) begin
            len_d = shifted;
            if (shifted == 32'd0)          state_d = S_DONE;
            else if (shifted > DEPTH_W)    state_d = S_ERR;
            else                           state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q == 2'd3) begin
            wr_en   = 1'b1;
            words_d = words_q + (AW+1)'(1);
            // Leave S_DATA on the same edge as the final write lands.
            if ({{(31-AW){1'b0}}, words_d} == len_q) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
    loaded_d   = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  // Fetch side: a request only counts once the program is loaded.
  always_comb begin
    done_d = enabled & loaded_q;
    pc_n_d = pc_n_q;
    if (enabled && loaded_q) pc_n_d = pc;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_LEN;
      cnt_q      <= 2'd0;
      asm_q      <= 32'd0;
      len_q      <= 32'd0;
      words_q    <= '0;
      rx_ready_q <= 1'b1;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      pc_n_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      len_q      <= len_d;
      words_q    <= words_d;
      rx_ready_q <= rx_ready_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      done_q     <= done_d;
      pc_n_q     <= pc_n_d;
    end
  end

  // Memory is deliberately not reset; words_loaded gates every read.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) mem[wr_idx] <= shifted;
  end

  // Full 32-bit compare so a pc with high bits set can never alias a low word.
  assign pc_in_range = pc < {{(31-AW){1'b0}}, words_q};
  assign rd_idx      = pc[AW-1:0];

  always_comb begin
    instr_raw = 32'd0;
    if (enabled && loaded_q && pc_in_range) instr_raw = mem[rd_idx];
  end

  assign rx_ready     = rx_ready_q;
  assign loaded       = loaded_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;
  assign completed    = done_q & ~enabled;
  assign pc_n         = pc_n_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: byte-stream loads checked by reading words back through the
// fetch port against an expected queue, plus a table of fetch vectors.
module tb_instr_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          loaded;
  logic          load_error;
  logic [AW:0]   words_loaded;
  logic          enabled = 1'b0;
  logic [31:0]   pc = 32'd0;
  logic [31:0]   instr_raw;
  logic          completed;
  logic [31:0]   pc_n;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] prog_q[$];

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
    logic [31:0] pc_n;
  } fvec_t;

  fvec_t tbl[10];

  instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .loaded(loaded), .load_error(load_error), .words_loaded(words_loaded),
    .enabled(enabled), .pc(pc), .instr_raw(instr_raw),
    .completed(completed), .pc_n(pc_n)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    rx_valid = 1'b0;
    enabled = 1'b0;
    pc = 32'd0;
    tick;
    tick;
    rstn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
        tick;
      end
    end
    rx_valid = 1'b1;
    rx_data = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      tick;
      n++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    end else begin
      tick;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  // Sends the header plus every word in prog_q, pushing each word as expected output.
  task automatic load_program(input bit gaps);
    send_word(32'(prog_q.size()), gaps);
    foreach (prog_q[i]) begin
      exp_q.push_back(prog_q[i]);
      send_word(prog_q[i], gaps);
    end
  endtask

  task automatic readback(input int n);
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      enabled = 1'b1;
      pc = 32'(i);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("readback_queue_empty", 32'd0, 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("readback_pc%0d", i), instr_raw, exp);
      end
      tick;
    end
    enabled = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0000, 32'h08C0_00EF, 1'b0, 32'h0000_0001};
    tbl[1] = '{1'b1, 32'h0000_0002, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[2] = '{1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0002};
    tbl[3] = '{1'b1, 32'h8000_0001, 32'h0000_0000, 1'b0, 32'h0000_0002};
    tbl[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h8000_0001};
    tbl[5] = '{1'b1, 32'h0000_0041, 32'h0000_0000, 1'b0, 32'h8000_0001};
    tbl[6] = '{1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0000_0041};
    tbl[7] = '{1'b1, 32'h0001_0001, 32'h0000_0000, 1'b0, 32'h0000_0040};
    tbl[8] = '{1'b1, 32'h0000_0001, 32'hFE01_0113, 1'b0, 32'h0001_0001};
    tbl[9] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001};

    // Reset values, sampled while rstn is still low.
    rstn = 1'b0;
    tick;
    tick;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_completed", 32'(completed), 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    check("rst_pc_n", pc_n, 32'd0);
    rstn = 1'b1;

    // Two-word reference load.
    prog_q = '{32'h08C0_00EF, 32'hFE01_0113};
    load_program(1'b0);
    check("load2_loaded", 32'(loaded), 32'd1);
    check("load2_rx_ready", 32'(rx_ready), 32'd0);
    check("load2_words", 32'(words_loaded), 32'd2);

    // Single-cycle fetch followed by release.
    enabled = 1'b1;
    pc = 32'd1;
    @(negedge clk);
    check("fetch_instr", instr_raw, 32'hFE01_0113);
    check("fetch_completed_early", 32'(completed), 32'd0);
    tick;
    enabled = 1'b0;
    @(negedge clk);
    check("fetch_completed", 32'(completed), 32'd1);
    check("fetch_pc_n", pc_n, 32'd1);
    tick;
    @(negedge clk);
    check("fetch_completed_drop", 32'(completed), 32'd0);
    tick;

    readback(2);
    tick;
    tick;

    for (int i = 0; i < 10; i++) begin
      enabled = tbl[i].en;
      pc = tbl[i].pc;
      @(negedge clk);
      check($sformatf("tbl%0d_instr", i), instr_raw, tbl[i].instr);
      check($sformatf("tbl%0d_completed", i), 32'(completed), 32'(tbl[i].comp));
      check($sformatf("tbl%0d_pc_n", i), pc_n, tbl[i].pc_n);
      tick;
    end
    enabled = 1'b0;

    // Fetch before loading must not register; then an empty program.
    do_reset;
    enabled = 1'b1;
    pc = 32'd5;
    tick;
    enabled = 1'b0;
    @(negedge clk);
    check("preload_completed", 32'(completed), 32'd0);
    check("preload_pc_n", pc_n, 32'd0);
    tick;
    send_word(32'd0, 1'b0);
    check("empty_loaded", 32'(loaded), 32'd1);
    check("empty_rx_ready", 32'(rx_ready), 32'd0);
    check("empty_words", 32'(words_loaded), 32'd0);
    enabled = 1'b1;
    pc = 32'd0;
    @(negedge clk);
    check("empty_fetch", instr_raw, 32'd0);
    tick;
    enabled = 1'b0;

    // Oversized header locks into the error state.
    do_reset;
    send_word(32'h0000_0041, 1'b0);
    check("err_load_error", 32'(load_error), 32'd1);
    check("err_rx_ready", 32'(rx_ready), 32'd0);
    check("err_loaded", 32'(loaded), 32'd0);
    rx_valid = 1'b1;
    rx_data = 8'hAA;
    repeat (6) tick;
    rx_valid = 1'b0;
    check("err_words", 32'(words_loaded), 32'd0);
    check("err_hold", 32'(load_error), 32'd1);
    check("err_hold_ready", 32'(rx_ready), 32'd0);

    // Header exactly DEPTH fills the whole memory.
    do_reset;
    prog_q.delete();
    for (int i = 0; i < DEPTH; i++) prog_q.push_back($urandom);
    load_program(1'b0);
    check("full_load_error", 32'(load_error), 32'd0);
    check("full_loaded", 32'(loaded), 32'd1);
    check("full_words", 32'(words_loaded), 32'(DEPTH));
    readback(DEPTH);
    enabled = 1'b1;
    pc = 32'(DEPTH);
    @(negedge clk);
    check("full_past_end", instr_raw, 32'd0);
    tick;
    enabled = 1'b0;

    // Three-word load with random gaps in rx_valid.
    do_reset;
    prog_q = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C};
    load_program(1'b1);
    check("gap_loaded", 32'(loaded), 32'd1);
    check("gap_words", 32'(words_loaded), 32'd3);
    readback(3);

    // Reset after six data bytes, then a fresh one-word load.
    do_reset;
    send_word(32'd2, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    do_reset;
    check("abort_words", 32'(words_loaded), 32'd0);
    check("abort_rx_ready", 32'(rx_ready), 32'd1);
    prog_q = '{32'h0000_0073};
    load_program(1'b0);
    check("reload_words", 32'(words_loaded), 32'd1);
    check("reload_loaded", 32'(loaded), 32'd1);
    readback(1);
    enabled = 1'b1;
    pc = 32'd1;
    @(negedge clk);
    check("reload_pc1", instr_raw, 32'd0);
    tick;
    enabled = 1'b0;

    if (exp_q.size() != 0) check("exp_q_leftover", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter AW, default 6, meaning word-index width, with 2**AW >= DEPTH.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port rx_valid  input  1  byte-stream source has a byte on rx_data.
REQ-006 SHALL have port rx_data  input  8  program byte.
REQ-007 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port loaded  output  1  program fully written; fetch port live.
REQ-009 SHALL have port load_error  output  1  declared length exceeded DEPTH.
REQ-010 SHALL have port words_loaded  output  AW+1  count of words written so far.
REQ-011 SHALL have port enabled  input  1  fetch request from the fetch stage.
REQ-012 SHALL have port pc  input  32  word index of the requested instruction.
REQ-013 SHALL have port instr_raw  output  32  instruction word, combinational from pc.
REQ-014 SHALL have port completed  output  1  fetch-done strobe.
REQ-015 SHALL have port pc_n  output  32  registered copy of the last served pc.

Function
REQ-016 SHALL transfer a byte only on a cycle with rx_valid=1 and rx_ready=1.
REQ-017 SHALL implement states S_LEN, S_DATA, S_DONE and S_ERR.
REQ-018 SHALL drive rx_ready=1 in S_LEN and S_DATA, and rx_ready=0 in S_DONE and S_ERR.
REQ-019 SHALL in S_LEN assemble 4 accepted bytes little-endian into the 32-bit length N, with byte counter 0..3.
REQ-020 SHALL on the 4th length byte go to S_DONE if N=0, to S_ERR if N>DEPTH, otherwise to S_DATA.
REQ-021 SHALL in S_DATA assemble 4 accepted bytes little-endian into one word.
REQ-022 SHALL on the cycle the 4th data byte is accepted write mem[words_loaded] = {b3,b2,b1,b0} and increment words_loaded, with no extra latency cycle.
REQ-023 SHALL go to S_DONE on the same edge that words_loaded reaches N.
REQ-024 SHALL hold S_DONE and S_ERR until reset, ignoring rx_valid.
REQ-025 SHALL drive loaded=1 exactly in S_DONE and load_error=1 exactly in S_ERR.
REQ-026 SHALL set instr_raw = mem[pc] when enabled=1, loaded=1 and pc < words_loaded, and 0 otherwise; pc is a word index.
REQ-027 SHALL return 0 for pc >= words_loaded, including any pc with upper bits set; pc is never truncated.
REQ-028 SHALL each cycle register done_r <= enabled & loaded, with pc_n <= pc when enabled & loaded and pc_n held otherwise.
REQ-029 SHALL drive completed = done_r & ~enabled.
REQ-030 SHALL keep a fetch issued while loaded=0 from affecting pc_n and from raising completed.

Reset
REQ-031 SHALL, on a clock edge with rstn=0, set state=S_LEN, byte counter=0, N=0, words_loaded=0, done_r=0 and pc_n=0.
REQ-032 SHALL drive loaded=0, load_error=0, completed=0 and rx_ready=1 from the first cycle after reset.
REQ-033 SHALL leave memory contents uncleared on reset; stale words stay unreadable because words_loaded=0.
REQ-034 SHALL, on reset during S_DATA, discard the partial word; a new load restarts with the length header.

Verification
REQ-035 SHALL cover: bytes 02 00 00 00, EF 00 C0 08, 13 01 01 FE -> words_loaded=2, loaded=1, mem[0]=08C000EF, mem[1]=FE010113.
REQ-036 SHALL cover: after the 035 load, enabled=1 with pc=1 for 1 cycle, then enabled=0 -> instr_raw=FE010113 during the request, completed=1 on the next cycle, pc_n=1.
REQ-037 SHALL cover: length header 00 00 00 00 -> loaded=1 and rx_ready=0 one cycle after the 4th byte; fetch of pc=0 returns 0.
REQ-038 SHALL cover: length header 41 00 00 00 with DEPTH=64 -> load_error=1, rx_ready=0, loaded=0, and further bytes are not accepted.
REQ-039 SHALL cover: rx_valid toggled 1/0 randomly through a 3-word load -> words identical to a gap-free load, with no byte lost or duplicated.
REQ-040 SHALL cover: rstn=0 after 6 data bytes of a 2-word load, then a full 1-word load of 00000073 -> words_loaded=1, pc=0 reads 00000073, pc=1 reads 0.
